// File: rtl/gate_unit_pipe.sv
// Two-stage pipelined bitwise gate unit with valid/ready handshake.
// A SWEEP request replays one operand pair through all seven gate ops in order.
module gate_unit_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic             in_sweep,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [2:0]       out_op,
  output logic             out_err,
  output logic             out_last,
  output logic [CNT_W-1:0] res_count
);
  localparam int STAGES = 2;
  localparam logic [2:0] LAST_OP = 3'd6;

  typedef enum logic {IDLE, SWEEP} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             last;
  } s1_t;

  state_t            state, nextState;
  logic [2:0]        sweepIdx, nextIdx;
  logic [WIDTH-1:0]  aLat, bLat;
  logic [STAGES-1:0] vldPipe;
  s1_t               s1, s1Next;
  logic              s1Load, adv, inXfer, latchAB;
  logic [WIDTH-1:0]  resData;
  logic              resErr;

  // Both stages move together; a held output stalls the whole pipe.
  assign adv      = ~vldPipe[STAGES-1] | out_ready;
  assign in_ready = rst_n & adv & (state == IDLE);
  assign inXfer   = in_valid & in_ready;
  assign out_valid = vldPipe[STAGES-1];

  always_comb begin
    nextState = state;
    nextIdx   = sweepIdx;
    s1Load    = 1'b0;
    latchAB   = 1'b0;
    s1Next    = '{a: in_a, b: in_b, op: in_op, last: 1'b1};
    case (state)
      IDLE: begin
        if (inXfer) begin
          s1Load = 1'b1;
          if (in_sweep) begin
            latchAB     = 1'b1;
            s1Next.op   = 3'd0;
            s1Next.last = 1'b0;
            nextIdx     = 3'd1;
            nextState   = SWEEP;
          end
        end
      end
      SWEEP: begin
        if (adv) begin
          s1Load      = 1'b1;
          s1Next.a    = aLat;
          s1Next.b    = bLat;
          s1Next.op   = sweepIdx;
          s1Next.last = (sweepIdx == LAST_OP);
          nextIdx     = sweepIdx + 3'd1;
          if (sweepIdx == LAST_OP) nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    resErr  = 1'b0;
    resData = '0;
    case (s1.op)
      3'd0: resData = s1.a ^ s1.b;
      3'd1: resData = ~(s1.a ^ s1.b);
      3'd2: resData = s1.a & s1.b;
      3'd3: resData = ~(s1.a & s1.b);
      3'd4: resData = ~s1.a;
      3'd5: resData = s1.a | s1.b;
      3'd6: resData = ~(s1.a | s1.b);
      default: resErr = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      sweepIdx <= '0;
      aLat     <= '0;
      bLat     <= '0;
      vldPipe  <= '0;
      s1       <= '0;
      out_data <= '0;
      out_op   <= '0;
      out_err  <= 1'b0;
      out_last <= 1'b0;
    end else begin
      state    <= nextState;
      sweepIdx <= nextIdx;
      if (latchAB) begin
        aLat <= in_a;
        bLat <= in_b;
      end
      if (adv) begin
        vldPipe  <= {vldPipe[0], s1Load};
        s1       <= s1Next;
        out_data <= resData;
        out_op   <= s1.op;
        out_err  <= resErr;
        out_last <= s1.last;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) res_count <= '0;
    else if (out_valid & out_ready) res_count <= res_count + 1'b1;
  end
endmodule

// File: tb/tb_gate_unit_pipe.sv
// Directed bench for gate_unit_pipe (WIDTH=8, CNT_W=3 so the counter wrap is reachable).
module tb_gate_unit_pipe;
  logic       clk = 1'b0;
  logic       rst_n, in_valid, in_ready, in_sweep, out_valid, out_ready;
  logic       out_err, out_last;
  logic [7:0] in_a, in_b, out_data;
  logic [2:0] in_op, out_op, res_count;
  int         total = 0, fails = 0;

  logic [7:0] e1 [7] = '{8'h3C, 8'hC3, 8'hC0, 8'h3F, 8'h0F, 8'hFC, 8'h03};
  logic [7:0] e2 [7] = '{8'hA5, 8'h5A, 8'h0A, 8'hF5, 8'h55, 8'hAF, 8'h50};

  gate_unit_pipe #(.WIDTH(8), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_sweep(in_sweep),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_op(out_op), .out_err(out_err), .out_last(out_last), .res_count(res_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int idx;
    rst_n = 1'b0; in_valid = 1'b0; in_sweep = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_op = '0;

    // reset state
    tick(); tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_cnt", res_count, 0);
    chk("rst_ready", in_ready, 0);
    rst_n = 1'b1; #1;
    chk("rel_ready", in_ready, 1);

    // 1: single ops back to back
    in_a = 8'hF0; in_b = 8'hCC; in_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_op = 3'(i);
      tick();
      if (i > 0) begin
        chk("t1_data", out_data, e1[i-1]);
        chk("t1_op", out_op, i - 1);
        chk("t1_last", out_last, 1);
        chk("t1_cnt", res_count, i - 1);
      end
    end
    in_valid = 1'b0;
    tick();
    chk("t1_data6", out_data, e1[6]);
    chk("t1_valid6", out_valid, 1);
    tick();
    chk("t1_bubble", out_valid, 0);
    chk("t1_cnt7", res_count, 7);

    // 2: sweep
    in_a = 8'hAA; in_b = 8'h0F; in_sweep = 1'b1; in_valid = 1'b1; #1;
    chk("t2_rdy0", in_ready, 1);
    tick();
    in_valid = 1'b0; in_sweep = 1'b0; #1;
    chk("t2_busy", in_ready, 0);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("t2_valid", out_valid, 1);
      chk("t2_data", out_data, e2[i]);
      chk("t2_op", out_op, i);
      chk("t2_last", out_last, i == 6);
      chk("t2_ready", in_ready, i >= 5);
      chk("t2_cnt", res_count, (7 + i) % 8);
    end
    tick();
    chk("t2_end", out_valid, 0);
    chk("t2_cnt", res_count, 14 % 8);

    // 3: backpressure during sweep
    in_sweep = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; in_sweep = 1'b0;
    tick();
    chk("t3_op0", out_op, 0);
    tick();
    chk("t3_op1", out_op, 1);
    out_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      tick();
      chk("t3_hold_v", out_valid, 1);
      chk("t3_hold_op", out_op, 1);
      chk("t3_hold_d", out_data, 8'h5A);
      chk("t3_hold_rdy", in_ready, 0);
      chk("t3_hold_cnt", res_count, 15 % 8);
    end
    out_ready = 1'b1;
    idx = 1;
    for (int c = 0; c < 20 && idx < 7; c++) begin
      if (out_valid) begin
        chk("t3_op", out_op, idx);
        chk("t3_data", out_data, e2[idx]);
        idx++;
      end
      tick();
    end
    chk("t3_all", idx, 7);
    chk("t3_cnt", res_count, 21 % 8);
    chk("t3_end", out_valid, 0);

    // 4: illegal op, then legal
    in_valid = 1'b1; in_op = 3'd7; in_a = 8'hFF; in_b = 8'hFF;
    tick();
    in_op = 3'd0; in_b = 8'h00;
    tick();
    in_valid = 1'b0;
    chk("t4_data", out_data, 8'h00);
    chk("t4_err", out_err, 1);
    chk("t4_last", out_last, 1);
    chk("t4_op", out_op, 7);
    tick();
    chk("t4_ok_data", out_data, 8'hFF);
    chk("t4_ok_err", out_err, 0);
    tick();
    chk("t4_cnt", res_count, 23 % 8);

    // 5: reset after the third sweep result
    in_a = 8'hAA; in_b = 8'h0F; in_sweep = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; in_sweep = 1'b0;
    tick(); tick(); tick();
    chk("t5_op2", out_op, 2);
    rst_n = 1'b0; #1;
    chk("t5_rdy_rst", in_ready, 0);
    tick();
    chk("t5_valid", out_valid, 0);
    chk("t5_data", out_data, 0);
    chk("t5_op", out_op, 0);
    chk("t5_last", out_last, 0);
    chk("t5_cnt", res_count, 0);
    rst_n = 1'b1; #1;
    chk("t5_rdy", in_ready, 1);
    for (int s = 0; s < 3; s++) begin
      tick();
      chk("t5_quiet", out_valid, 0);
    end

    // 6: counter wrap over 9 transfers
    in_b = 8'h5A;
    for (int t = 1; t <= 12; t++) begin
      in_valid = (t <= 9);
      in_op = 3'((t - 1) % 7);
      in_a = 8'(t);
      tick();
      chk("t6_cnt", res_count, ((t < 2) ? 0 : (t - 2 > 9 ? 9 : t - 2)) % 8);
      if (t >= 2 && t <= 10) chk("t6_op", out_op, (t - 2) % 7);
    end
    chk("t6_end", out_valid, 0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
